// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: opcode classes, decode stall-FSM states, immediate generation.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_t;

    // 64-bit immediate; narrower datapaths truncate (sign is already replicated).
    function automatic logic [63:0] imm_gen(input logic [31:0] ir, input logic xlen64);
        logic [63:0] imm;
        logic        is_shift;
        imm      = '0;
        is_shift = (ir[14:12] == 3'b001) || (ir[14:12] == 3'b101);
        case (ir[6:0])
            OPC_LOAD, OPC_JALR, OPC_SYSTEM:
                imm = {{52{ir[31]}}, ir[31:20]};
            OPC_OP_IMM:
                if (is_shift) imm = xlen64 ? {58'd0, ir[25:20]} : {59'd0, ir[24:20]};
                else          imm = {{52{ir[31]}}, ir[31:20]};
            OPC_OP_IMM32:
                if (is_shift) imm = {59'd0, ir[24:20]};
                else          imm = {{52{ir[31]}}, ir[31:20]};
            OPC_STORE:
                imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:
                imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {{32{ir[31]}}, ir[31:12], 12'd0};
            OPC_JAL:
                imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// DE-side, forwarding, hazard and EXE-register signals of the decode/issue stage.
interface decode_issue_stage_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NFWD = 2
);
    logic               de_v;
    logic [31:0]        de_ir;
    logic [XLEN-1:0]    de_npc;
    logic [XLEN-1:0]    rf_rs1;
    logic [XLEN-1:0]    rf_rs2;
    logic [NFWD-1:0]    fwd_v;
    logic [5*NFWD-1:0]  fwd_rd;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic               exe_ld_v;
    logic [4:0]         exe_ld_rd;
    logic               mem_stall;
    logic               br_resolve;
    logic               flush;
    logic               de_ready;
    logic               exe_v;
    logic               exe_ecall;
    logic [31:0]        exe_ir;
    logic [XLEN-1:0]    exe_npc;
    logic [XLEN-1:0]    exe_op1;
    logic [XLEN-1:0]    exe_op2;
    logic [XLEN-1:0]    exe_st_data;
    logic [XLEN-1:0]    exe_imm;

    modport master (
        output de_v, de_ir, de_npc, rf_rs1, rf_rs2, fwd_v, fwd_rd, fwd_data,
               exe_ld_v, exe_ld_rd, mem_stall, br_resolve, flush,
        input  de_ready, exe_v, exe_ecall, exe_ir, exe_npc, exe_op1, exe_op2,
               exe_st_data, exe_imm
    );

    modport slave (
        input  de_v, de_ir, de_npc, rf_rs1, rf_rs2, fwd_v, fwd_rd, fwd_data,
               exe_ld_v, exe_ld_rd, mem_stall, br_resolve, flush,
        output de_ready, exe_v, exe_ecall, exe_ir, exe_npc, exe_op1, exe_op2,
               exe_st_data, exe_imm
    );
endinterface

// File: rtl/operand_fwd_mux.sv
// Priority operand select: x0 forces zero, else lowest-index matching forward source, else RF data.
module operand_fwd_mux #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NFWD = 2
) (
    input  logic [4:0]           rs,
    input  logic [XLEN-1:0]      rf,
    input  logic [NFWD-1:0]      fwd_v,
    input  logic [5*NFWD-1:0]    fwd_rd,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic [XLEN-1:0]      operand_c
);
    always_comb begin
        operand_c = rf;
        // Walk oldest to youngest so the lowest matching index is left standing.
        for (int i = int'(NFWD) - 1; i >= 0; i--) begin
            if (fwd_v[i] && (fwd_rd[i*5 +: 5] == rs)) operand_c = fwd_data[i*XLEN +: XLEN];
        end
        if (rs == 5'd0) operand_c = '0;
    end
endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: immediates, forwarded operand select, load-use interlock,
// branch-wait FSM and the DE->EXE pipeline register.
module decode_issue_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NFWD = 2
) (
    input logic                  CLK,
    input logic                  reset,
    decode_issue_stage_if.slave  bus
);
    logic [6:0]      opc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            is_ctl;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            is_ecall;
    logic            lu;
    logic            issue;
    state_t          state;

    assign opc = bus.de_ir[6:0];
    assign rs1 = bus.de_ir[19:15];
    assign rs2 = bus.de_ir[24:20];

    operand_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
        .rs(rs1), .rf(bus.rf_rs1), .fwd_v(bus.fwd_v), .fwd_rd(bus.fwd_rd),
        .fwd_data(bus.fwd_data), .operand_c(rs1_val)
    );

    operand_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
        .rs(rs2), .rf(bus.rf_rs2), .fwd_v(bus.fwd_v), .fwd_rd(bus.fwd_rd),
        .fwd_data(bus.fwd_data), .operand_c(rs2_val)
    );

    assign imm      = XLEN'(imm_gen(bus.de_ir, XLEN == 64));
    assign is_ctl   = (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    assign uses_rs1 = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    assign uses_rs2 = (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_OP) || (opc == OPC_OP32);
    assign is_ecall = (bus.de_ir == 32'h0000_0073);

    // Load-use interlock against the load currently in EXE.
    assign lu = bus.de_v && bus.exe_ld_v && (bus.exe_ld_rd != 5'd0) &&
                ((uses_rs1 && (bus.exe_ld_rd == rs1)) || (uses_rs2 && (bus.exe_ld_rd == rs2)));

    assign bus.de_ready = !bus.mem_stall && !lu && (state == RUN);
    assign issue        = bus.de_ready && bus.de_v && !bus.flush;

    always_comb begin
        op1 = rs1_val;
        if ((opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR)) op1 = bus.de_npc;
        else if (opc == OPC_LUI)                                         op1 = '0;
    end

    // Jumps carry the target offset in exe_imm and the link increment in op2.
    always_comb begin
        op2 = imm;
        if ((opc == OPC_OP) || (opc == OPC_OP32) || (opc == OPC_BRANCH)) op2 = rs2_val;
        else if ((opc == OPC_JAL) || (opc == OPC_JALR))                  op2 = XLEN'(4);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state           <= RUN;
            bus.exe_v       <= 1'b0;
            bus.exe_ecall   <= 1'b0;
            bus.exe_ir      <= '0;
            bus.exe_npc     <= '0;
            bus.exe_op1     <= '0;
            bus.exe_op2     <= '0;
            bus.exe_st_data <= '0;
            bus.exe_imm     <= '0;
        end else begin
            if (bus.flush || ((state == BR_WAIT) && bus.br_resolve)) state <= RUN;
            else if (issue && is_ctl)                                 state <= BR_WAIT;

            if (!bus.mem_stall) begin
                if (issue) begin
                    bus.exe_v       <= 1'b1;
                    bus.exe_ecall   <= is_ecall;
                    bus.exe_ir      <= bus.de_ir;
                    bus.exe_npc     <= bus.de_npc;
                    bus.exe_op1     <= op1;
                    bus.exe_op2     <= op2;
                    bus.exe_st_data <= rs2_val;
                    bus.exe_imm     <= imm;
                end else begin
                    bus.exe_v       <= 1'b0;
                    bus.exe_ecall   <= 1'b0;
                    bus.exe_ir      <= '0;
                    bus.exe_npc     <= '0;
                    bus.exe_op1     <= '0;
                    bus.exe_op2     <= '0;
                    bus.exe_st_data <= '0;
                    bus.exe_imm     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: vector table on a 64-bit instance, hand
// sequences for interlock/branch/stall/flush/reset, and a 32-bit instance for shift immediates.
module tb_decode_issue_stage;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    decode_issue_stage_if #(.XLEN(64), .NFWD(2)) bus ();
    decode_issue_stage_if #(.XLEN(32), .NFWD(2)) bus32 ();

    decode_issue_stage #(.XLEN(64), .NFWD(2)) dut (.CLK(CLK), .reset(reset), .bus(bus));
    decode_issue_stage #(.XLEN(32), .NFWD(2)) dut32 (.CLK(CLK), .reset(reset), .bus(bus32));

    typedef struct {
        logic [31:0] ir;
        logic [63:0] npc, op1, op2, st, imm;
        logic        ecall;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        logic [63:0] rf1, rf2;
        logic [1:0]  fv;
        logic [4:0]  rd0, rd1;
        logic [63:0] fd0, fd1;
        logic [63:0] op1, op2, st, imm;
        logic        ecall;
    } vec_t;

    exp_t sb[$];
    exp_t last;
    vec_t tv[13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp_rec(input string tag, input exp_t e);
        chk({tag, " ir"},    64'(bus.exe_ir),      64'(e.ir));
        chk({tag, " npc"},   bus.exe_npc,          e.npc);
        chk({tag, " op1"},   bus.exe_op1,          e.op1);
        chk({tag, " op2"},   bus.exe_op2,          e.op2);
        chk({tag, " st"},    bus.exe_st_data,      e.st);
        chk({tag, " imm"},   bus.exe_imm,          e.imm);
        chk({tag, " ecall"}, 64'(bus.exe_ecall),   64'(e.ecall));
    endtask

    // Pops the scoreboard whenever the EXE register shows a valid instruction.
    task automatic check_exe(input string tag, input logic exp_v);
        chk({tag, " exe_v"}, 64'(bus.exe_v), 64'(exp_v));
        if (bus.exe_v) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: exe_v=1 with empty scoreboard", tag);
            end else begin
                last = sb.pop_front();
                cmp_rec(tag, last);
            end
        end
    endtask

    task automatic push(input logic [31:0] ir, input logic [63:0] npc, input logic [63:0] op1,
                        input logic [63:0] op2, input logic [63:0] st, input logic [63:0] imm,
                        input logic ecall);
        exp_t e;
        e.ir = ir; e.npc = npc; e.op1 = op1; e.op2 = op2; e.st = st; e.imm = imm; e.ecall = ecall;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [63:0] npc);
        bus.de_v   = v;
        bus.de_ir  = ir;
        bus.de_npc = npc;
    endtask

    initial begin
        tv[0]  = '{32'hFFF00093, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tv[1]  = '{32'h002081B3, 64'h11, 64'h7, 2'b11, 5'd1, 5'd1, 64'h5, 64'h9,
                   64'h5, 64'h7, 64'h7, 64'h0, 1'b0};
        tv[2]  = '{32'h002001B3, 64'h11, 64'h7, 2'b11, 5'd0, 5'd1, 64'h5, 64'h9,
                   64'h0, 64'h7, 64'h7, 64'h0, 1'b0};
        tv[3]  = '{32'h002081B3, 64'h11, 64'h22, 2'b11, 5'd4, 5'd2, 64'h44, 64'h99,
                   64'h11, 64'h99, 64'h99, 64'h0, 1'b0};
        tv[4]  = '{32'hFE20AE23, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h11, 64'hFFFF_FFFF_FFFF_FFFC, 64'h22, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tv[5]  = '{32'h800002B7, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h0, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0};
        tv[6]  = '{32'h00001297, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h1000, 64'h1000, 64'h0, 64'h1000, 1'b0};
        tv[7]  = '{32'h03F09093, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h11, 64'd63, 64'h22, 64'd63, 1'b0};
        tv[8]  = '{32'h4050D093, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h11, 64'd5, 64'h22, 64'd5, 1'b0};
        tv[9]  = '{32'h00000073, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h0, 64'h0, 64'h0, 64'h0, 1'b1};
        tv[10] = '{32'h0080B283, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h11, 64'd8, 64'h22, 64'd8, 1'b0};
        tv[11] = '{32'h01F0909B, 64'h11, 64'h22, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0,
                   64'h11, 64'd31, 64'h22, 64'd31, 1'b0};
        tv[12] = '{32'h002081BB, 64'h11, 64'h22, 2'b01, 5'd2, 5'd0, 64'h55, 64'h0,
                   64'h11, 64'h55, 64'h55, 64'h0, 1'b0};

        bus.rf_rs1 = 64'h11; bus.rf_rs2 = 64'h22;
        bus.fwd_v = '0; bus.fwd_rd = '0; bus.fwd_data = '0;
        bus.exe_ld_v = 1'b0; bus.exe_ld_rd = '0;
        bus.mem_stall = 1'b0; bus.br_resolve = 1'b0; bus.flush = 1'b0;
        drive(1'b1, 32'hFFF00093, 64'h1000);
        bus32.de_v = 1'b0; bus32.de_ir = '0; bus32.de_npc = '0;
        bus32.rf_rs1 = 32'h11; bus32.rf_rs2 = 32'h22;
        bus32.fwd_v = '0; bus32.fwd_rd = '0; bus32.fwd_data = '0;
        bus32.exe_ld_v = 1'b0; bus32.exe_ld_rd = '0;
        bus32.mem_stall = 1'b0; bus32.br_resolve = 1'b0; bus32.flush = 1'b0;

        // Reset blocks capture even with a valid DE instruction present.
        step(); step();
        check_exe("reset", 1'b0);
        chk("reset op1", bus.exe_op1, 64'h0);
        chk("reset imm", bus.exe_imm, 64'h0);
        chk("reset ir", 64'(bus.exe_ir), 64'h0);
        reset = 1'b0;
        #1;
        chk("reset de_ready", 64'(bus.de_ready), 64'h1);

        // Table-driven single-cycle decode.
        for (int i = 0; i < 13; i++) begin
            bus.rf_rs1 = tv[i].rf1; bus.rf_rs2 = tv[i].rf2;
            bus.fwd_v = tv[i].fv;
            bus.fwd_rd = {tv[i].rd1, tv[i].rd0};
            bus.fwd_data = {tv[i].fd1, tv[i].fd0};
            drive(1'b1, tv[i].ir, 64'h1000);
            push(tv[i].ir, 64'h1000, tv[i].op1, tv[i].op2, tv[i].st, tv[i].imm, tv[i].ecall);
            step();
            check_exe($sformatf("vec%0d", i), 1'b1);
        end
        bus.rf_rs1 = 64'h11; bus.rf_rs2 = 64'h22; bus.fwd_v = '0;
        drive(1'b0, 32'h0, 64'h0);
        step();
        check_exe("idle", 1'b0);

        // Load-use: one bubble, then forward from source 0.
        bus.exe_ld_v = 1'b1; bus.exe_ld_rd = 5'd5;
        drive(1'b1, 32'h00028333, 64'h2000);
        #1;
        chk("lu de_ready", 64'(bus.de_ready), 64'h0);
        step();
        check_exe("lu bubble", 1'b0);
        bus.exe_ld_v = 1'b0;
        bus.fwd_v = 2'b01; bus.fwd_rd = {5'd0, 5'd5}; bus.fwd_data = {64'h0, 64'h1234};
        #1;
        chk("lu release de_ready", 64'(bus.de_ready), 64'h1);
        push(32'h00028333, 64'h2000, 64'h1234, 64'h0, 64'h0, 64'h0, 1'b0);
        step();
        check_exe("lu fwd", 1'b1);
        bus.fwd_v = '0;
        bus.exe_ld_v = 1'b1; bus.exe_ld_rd = 5'd2;
        drive(1'b1, 32'hFE20AE23, 64'h2004);
        #1;
        chk("lu store rs2", 64'(bus.de_ready), 64'h0);
        bus.exe_ld_rd = 5'd0;
        #1;
        chk("lu rd0 ignored", 64'(bus.de_ready), 64'h1);
        bus.exe_ld_v = 1'b0;

        // Branch: BR_WAIT holds the next instruction until br_resolve.
        drive(1'b1, 32'h00208463, 64'h3000);
        push(32'h00208463, 64'h3000, 64'h11, 64'h22, 64'h22, 64'h8, 1'b0);
        step();
        check_exe("beq issue", 1'b1);
        drive(1'b1, 32'hFFF00093, 64'h3004);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("br_wait de_ready c%0d", c), 64'(bus.de_ready), 64'h0);
            step();
            check_exe($sformatf("br_wait c%0d", c), 1'b0);
        end
        bus.br_resolve = 1'b1;
        step();
        check_exe("br_resolve edge", 1'b0);
        bus.br_resolve = 1'b0;
        #1;
        chk("post resolve de_ready", 64'(bus.de_ready), 64'h1);
        push(32'hFFF00093, 64'h3004, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        check_exe("held issue", 1'b1);

        // mem_stall freezes the EXE register for two cycles.
        bus.mem_stall = 1'b1;
        drive(1'b1, 32'h0080B283, 64'h3008);
        #1;
        chk("stall de_ready", 64'(bus.de_ready), 64'h0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk($sformatf("stall hold v c%0d", c), 64'(bus.exe_v), 64'h1);
            cmp_rec($sformatf("stall hold c%0d", c), last);
        end
        bus.mem_stall = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        step();
        check_exe("stall release idle", 1'b0);

        // flush during BR_WAIT returns to RUN with no issue that cycle.
        drive(1'b1, 32'h0100006F, 64'h4000);
        push(32'h0100006F, 64'h4000, 64'h4000, 64'h4, 64'h22, 64'd16, 1'b0);
        step();
        check_exe("jal issue", 1'b1);
        drive(1'b1, 32'hFFF00093, 64'h4010);
        bus.flush = 1'b1;
        step();
        check_exe("flush", 1'b0);
        bus.flush = 1'b0;
        #1;
        chk("post flush de_ready", 64'(bus.de_ready), 64'h1);
        push(32'hFFF00093, 64'h4010, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        check_exe("post flush issue", 1'b1);

        // Reset mid-BR_WAIT returns to RUN.
        drive(1'b1, 32'h000100E7, 64'h5000);
        push(32'h000100E7, 64'h5000, 64'h5000, 64'h4, 64'h0, 64'h0, 1'b0);
        step();
        check_exe("jalr issue", 1'b1);
        reset = 1'b1;
        drive(1'b1, 32'hFFF00093, 64'h5004);
        step();
        check_exe("reset in br_wait", 1'b0);
        reset = 1'b0;
        #1;
        chk("post reset de_ready", 64'(bus.de_ready), 64'h1);
        push(32'hFFF00093, 64'h5004, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        check_exe("post reset issue", 1'b1);
        chk("scoreboard drained", 64'(sb.size()), 64'h0);

        // XLEN=32 instance: shamt width, sign extension and ecall.
        bus32.de_v = 1'b1; bus32.de_ir = 32'h01F09093; bus32.de_npc = 32'h100;
        step();
        chk("x32 slli v", 64'(bus32.exe_v), 64'h1);
        chk("x32 slli op2", 64'(bus32.exe_op2), 64'd31);
        bus32.de_ir = 32'h4250D093;
        step();
        chk("x32 srai op2", 64'(bus32.exe_op2), 64'd5);
        chk("x32 srai imm", 64'(bus32.exe_imm), 64'd5);
        bus32.de_ir = 32'hFFF00093;
        step();
        chk("x32 addi op2", 64'(bus32.exe_op2), 64'hFFFF_FFFF);
        bus32.de_ir = 32'h00000073;
        step();
        chk("x32 ecall", 64'(bus32.exe_ecall), 64'h1);
        bus32.de_v = 1'b0;
        step();
        chk("x32 idle", 64'(bus32.exe_v), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
